// File: rtl/awb_gain.sv
// Auto-white-balance gain engine: accumulates per-channel Bayer sums over a frame,
// then derives Q8.8 red/blue gains relative to green with a shared restoring divider.
module awb_gain #(
  parameter int G_SHIFT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [1:0]  color_i,
  input  logic [7:0]  value_i,
  input  logic        last_i,
  output logic        valid_o,
  output logic [1:0]  color_o,
  output logic [7:0]  value_o,
  output logic        last_o,
  output logic [15:0] K_R,
  output logic [15:0] K_G,
  output logic [15:0] K_B,
  output logic        valid_gain_o,
  output logic        busy_o,
  output logic        frame_drop_o
);

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DIV_R = 2'd1,
    DIV_B = 2'd2,
    LOAD  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] sr_q, sr_d, sg_q, sg_d, sb_q, sb_d;
  logic [31:0] dr_q, dr_d, db_q, db_d, n_q, n_d;
  logic [32:0] rem_q, rem_d;
  logic [15:0] dvd_q, dvd_d;
  logic [15:0] quo_q, quo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] res_r_q, res_r_d, res_b_q, res_b_d;
  logic [15:0] kr_q, kr_d, kb_q, kb_d;
  logic        vg_q, vg_d;
  logic        busy_q, busy_d;
  logic        drop_q, drop_d;
  logic        valid_q, last_q;
  logic [1:0]  color_q;
  logic [7:0]  value_q;

  logic        frame_end_s;
  logic        busy_s;
  logic [31:0] sr_add_s, sg_add_s, sb_add_s, n_new_s;
  logic [31:0] d_cur_s;
  logic [32:0] rem_sh_s, rem_step_s;
  logic        qbit_s;
  logic [15:0] quo_step_s;

  function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [7:0] val);
    logic [32:0] sum;
    sum = {1'b0, acc} + {25'd0, val};
    if (sum[32]) begin
      sat_add = 32'hFFFF_FFFF;
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

  // Zero denominator means "no information": keep unity; ratios of 16 or more clamp.
  function automatic logic [15:0] gain_sel(input logic [31:0] n, input logic [31:0] d,
                                           input logic [15:0] quo);
    if (d == 32'd0) begin
      gain_sel = 16'h0100;
    end else if ({4'd0, n} >= {d, 4'd0}) begin
      gain_sel = 16'h0FFF;
    end else begin
      gain_sel = quo;
    end
  endfunction

  // Accumulator adds and one restoring-division step for the active channel.
  always_comb begin
    frame_end_s = valid_i & last_i;
    busy_s      = (state_q != ACC);
    sr_add_s    = (valid_i && color_i == 2'd0) ? sat_add(sr_q, value_i) : sr_q;
    sg_add_s    = (valid_i && color_i == 2'd1) ? sat_add(sg_q, value_i) : sg_q;
    sb_add_s    = (valid_i && color_i == 2'd2) ? sat_add(sb_q, value_i) : sb_q;
    n_new_s     = sg_add_s >> G_SHIFT;
    d_cur_s     = (state_q == DIV_B) ? db_q : dr_q;
    rem_sh_s    = {rem_q[31:0], dvd_q[15]};
    if (rem_sh_s >= {1'b0, d_cur_s}) begin
      rem_step_s = rem_sh_s - {1'b0, d_cur_s};
      qbit_s     = 1'b1;
    end else begin
      rem_step_s = rem_sh_s;
      qbit_s     = 1'b0;
    end
    quo_step_s = {quo_q[14:0], qbit_s};
  end

  // Next-state logic for the gain FSM, snapshot and divider.
  always_comb begin
    state_d = state_q;
    dr_d    = dr_q;
    db_d    = db_q;
    n_d     = n_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    res_r_d = res_r_q;
    res_b_d = res_b_q;
    kr_d    = kr_q;
    kb_d    = kb_q;
    vg_d    = vg_q;
    if (frame_end_s) begin
      sr_d   = 32'd0;
      sg_d   = 32'd0;
      sb_d   = 32'd0;
      drop_d = busy_s;
    end else begin
      sr_d   = sr_add_s;
      sg_d   = sg_add_s;
      sb_d   = sb_add_s;
      drop_d = 1'b0;
    end
    case (state_q)
      ACC: begin
        if (frame_end_s) begin
          dr_d    = sr_add_s;
          db_d    = sb_add_s;
          n_d     = n_new_s;
          rem_d   = {9'd0, n_new_s[31:8]};
          dvd_d   = {n_new_s[7:0], 8'd0};
          quo_d   = 16'd0;
          cnt_d   = 4'd0;
          state_d = DIV_R;
        end else begin
          state_d = ACC;
        end
      end
      DIV_R: begin
        rem_d = rem_step_s;
        dvd_d = {dvd_q[14:0], 1'b0};
        quo_d = quo_step_s;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          res_r_d = gain_sel(n_q, dr_q, quo_step_s);
          rem_d   = {9'd0, n_q[31:8]};
          dvd_d   = {n_q[7:0], 8'd0};
          quo_d   = 16'd0;
          cnt_d   = 4'd0;
          state_d = DIV_B;
        end else begin
          state_d = DIV_R;
        end
      end
      DIV_B: begin
        rem_d = rem_step_s;
        dvd_d = {dvd_q[14:0], 1'b0};
        quo_d = quo_step_s;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          res_b_d = gain_sel(n_q, db_q, quo_step_s);
          cnt_d   = 4'd0;
          state_d = LOAD;
        end else begin
          state_d = DIV_B;
        end
      end
      LOAD: begin
        kr_d    = res_r_q;
        kb_d    = res_b_q;
        vg_d    = 1'b1;
        state_d = ACC;
      end
      default: begin
        state_d = ACC;
      end
    endcase
    busy_d = (state_d != ACC);
  end

  // Gain-path state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      sr_q    <= 32'd0;
      sg_q    <= 32'd0;
      sb_q    <= 32'd0;
      dr_q    <= 32'd0;
      db_q    <= 32'd0;
      n_q     <= 32'd0;
      rem_q   <= 33'd0;
      dvd_q   <= 16'd0;
      quo_q   <= 16'd0;
      cnt_q   <= 4'd0;
      res_r_q <= 16'h0100;
      res_b_q <= 16'h0100;
      kr_q    <= 16'h0100;
      kb_q    <= 16'h0100;
      vg_q    <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      sg_q    <= sg_d;
      sb_q    <= sb_d;
      dr_q    <= dr_d;
      db_q    <= db_d;
      n_q     <= n_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      res_r_q <= res_r_d;
      res_b_q <= res_b_d;
      kr_q    <= kr_d;
      kb_q    <= kb_d;
      vg_q    <= vg_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  // Pixel pass-through stage, independent of the gain FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      color_q <= 2'd0;
      value_q <= 8'd0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_i;
      color_q <= color_i;
      value_q <= value_i;
      last_q  <= last_i;
    end
  end

  assign valid_o      = valid_q;
  assign color_o      = color_q;
  assign value_o      = value_q;
  assign last_o       = last_q;
  assign K_R          = kr_q;
  assign K_G          = 16'h0100;
  assign K_B          = kb_q;
  assign valid_gain_o = vg_q;
  assign busy_o       = busy_q;
  assign frame_drop_o = drop_q;

endmodule

// File: tb/tb_awb_gain.sv
// Directed + random bench for awb_gain: frame-level reference model checked every cycle,
// plus literal expectations for the documented example frames.
module tb_awb_gain;

  localparam int G = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [1:0]  color_i = 2'd0;
  logic [7:0]  value_i = 8'd0;
  logic        last_i = 1'b0;
  logic        valid_o, last_o, valid_gain_o, busy_o, frame_drop_o;
  logic [1:0]  color_o;
  logic [7:0]  value_o;
  logic [15:0] K_R, K_G, K_B;

  int n_cmp = 0;
  int n_bad = 0;
  int drop_seen = 0;
  bit chk_en = 1'b0;

  // reference model state
  longint m_sr = 0, m_sg = 0, m_sb = 0;
  int     m_cnt = 0;
  int     m_pr = 256, m_pb = 256, m_kr = 256, m_kb = 256;
  bit     m_vg = 0, m_drop = 0;
  bit     m_v = 0, m_l = 0;
  int     m_c = 0, m_val = 0;

  awb_gain #(.G_SHIFT(G)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .color_i(color_i), .value_i(value_i),
    .last_i(last_i), .valid_o(valid_o), .color_o(color_o), .value_o(value_o), .last_o(last_o),
    .K_R(K_R), .K_G(K_G), .K_B(K_B), .valid_gain_o(valid_gain_o), .busy_o(busy_o),
    .frame_drop_o(frame_drop_o)
  );

  always #5 clk = ~clk;

  function automatic int exp_gain(input longint n, input longint d);
    if (d == 0) return 256;
    if (n >= d * 16) return 4095;
    return int'((n * 256) / d);
  endfunction

  function automatic longint sat32(input longint x);
    if (x > 64'h0000_0000_FFFF_FFFF) return 64'h0000_0000_FFFF_FFFF;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: a gain set becomes visible 33 edges after the edge that took last.
  always @(posedge clk or negedge rst_n) begin : model
    longint sr, sg, sb, n;
    int cnt, pr, pb, kr, kb;
    bit vg, drop, was_busy;
    if (!rst_n) begin
      m_sr <= 0; m_sg <= 0; m_sb <= 0; m_cnt <= 0;
      m_pr <= 256; m_pb <= 256; m_kr <= 256; m_kb <= 256;
      m_vg <= 0; m_drop <= 0; m_v <= 0; m_l <= 0; m_c <= 0; m_val <= 0;
    end else begin
      sr = m_sr; sg = m_sg; sb = m_sb; cnt = m_cnt;
      pr = m_pr; pb = m_pb; kr = m_kr; kb = m_kb; vg = m_vg;
      drop = 0;
      was_busy = (cnt != 0);
      if (cnt != 0) begin
        cnt++;
        if (cnt == 34) begin
          kr = pr; kb = pb; vg = 1; cnt = 0;
        end
      end
      if (valid_i) begin
        if (color_i == 2'd0) sr = sat32(sr + value_i);
        if (color_i == 2'd1) sg = sat32(sg + value_i);
        if (color_i == 2'd2) sb = sat32(sb + value_i);
        if (last_i) begin
          if (was_busy) begin
            drop = 1;
          end else begin
            n = sg >> G;
            pr = exp_gain(n, sr);
            pb = exp_gain(n, sb);
            cnt = 1;
          end
          sr = 0; sg = 0; sb = 0;
        end
      end
      m_sr <= sr; m_sg <= sg; m_sb <= sb; m_cnt <= cnt;
      m_pr <= pr; m_pb <= pb; m_kr <= kr; m_kb <= kb; m_vg <= vg; m_drop <= drop;
      m_v <= valid_i; m_c <= int'(color_i); m_val <= int'(value_i); m_l <= last_i;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid_o", {31'd0, valid_o}, {31'd0, m_v});
      chk("color_o", {30'd0, color_o}, m_c);
      chk("value_o", {24'd0, value_o}, m_val);
      chk("last_o", {31'd0, last_o}, {31'd0, m_l});
      chk("K_R", {16'd0, K_R}, m_kr);
      chk("K_G", {16'd0, K_G}, 32'h100);
      chk("K_B", {16'd0, K_B}, m_kb);
      chk("valid_gain_o", {31'd0, valid_gain_o}, {31'd0, m_vg});
      chk("busy_o", {31'd0, busy_o}, {31'd0, (m_cnt != 0)});
      chk("frame_drop_o", {31'd0, frame_drop_o}, {31'd0, m_drop});
    end
  end

  task automatic px(input bit v, input int c, input int val, input bit l);
    valid_i = v; color_i = 2'(c); value_i = 8'(val); last_i = l;
    @(posedge clk);
    #1;
    drop_seen += int'(frame_drop_o);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    idle(3);
    chk_en = 1'b1;
    chk("reset K_R", {16'd0, K_R}, 32'h100);
    chk("reset K_B", {16'd0, K_B}, 32'h100);
    chk("reset valid_gain", {31'd0, valid_gain_o}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // R=64 G=128 G=128 B=32: gains 2.0 / 4.0
    px(1, 0, 64, 0); px(1, 1, 128, 0); px(1, 1, 128, 0); px(1, 2, 32, 1);
    idle(32);
    chk("ex1 hold K_R@32", {16'd0, K_R}, 32'h100);
    chk("ex1 busy@32", {31'd0, busy_o}, 32'd1);
    idle(1);
    chk("ex1 K_R", {16'd0, K_R}, 32'h200);
    chk("ex1 K_B", {16'd0, K_B}, 32'h400);
    chk("ex1 K_G", {16'd0, K_G}, 32'h100);
    chk("ex1 valid_gain", {31'd0, valid_gain_o}, 32'd1);
    chk("ex1 busy done", {31'd0, busy_o}, 32'd0);

    // saturation and zero denominator; invalid color and unqualified last are ignored
    px(1, 3, 200, 0); px(0, 0, 99, 1);
    px(1, 1, 255, 0); px(1, 1, 255, 0); px(1, 0, 8, 0); px(1, 2, 0, 1);
    idle(33);
    chk("ex2 K_R sat", {16'd0, K_R}, 32'hFFF);
    chk("ex2 K_B zero", {16'd0, K_B}, 32'h100);

    // second frame ends 10 cycles after the first and is dropped
    px(1, 0, 10, 0); px(1, 1, 20, 0); px(1, 1, 20, 0); px(1, 2, 40, 1);
    drop_seen = 0;
    for (int i = 0; i < 9; i++) px(1, i % 3, 7, 0);
    px(1, 2, 9, 1);
    idle(22);
    chk("ex3 hold K_R@32", {16'd0, K_R}, 32'hFFF);
    idle(1);
    chk("ex3 K_R", {16'd0, K_R}, 32'h200);
    chk("ex3 K_B", {16'd0, K_B}, 32'h080);
    chk("ex3 drop count", drop_seen, 32'd1);

    // reset during DIV_B abandons the computation
    px(1, 0, 16, 0); px(1, 1, 128, 0); px(1, 1, 128, 0); px(1, 2, 64, 1);
    idle(20);
    #2 rst_n = 1'b0;
    #1;
    chk("rst K_R", {16'd0, K_R}, 32'h100);
    chk("rst K_B", {16'd0, K_B}, 32'h100);
    chk("rst valid_gain", {31'd0, valid_gain_o}, 32'd0);
    chk("rst busy", {31'd0, busy_o}, 32'd0);
    chk("rst valid_o", {31'd0, valid_o}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(40);
    chk("post-rst K_R", {16'd0, K_R}, 32'h100);
    chk("post-rst valid_gain", {31'd0, valid_gain_o}, 32'd0);

    // random stream, checked every cycle by the model
    for (int i = 0; i < 400; i++)
      px(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
         int'($urandom_range(0, 255)), ($urandom_range(0, 24) == 0));
    idle(40);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
